// File: rtl/gf180mcu_osu_sc_latch_bank_pkg.sv
// Shared types for the latch-bank write controller.
package gf180mcu_osu_sc_latch_bank_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        OPEN  = 2'd2,
        CLOSE = 2'd3
    } state_t;

endpackage

// File: rtl/gf180mcu_osu_sc_rr_arb.sv
// Combinational round-robin arbiter: first eligible requester at or after ptr wins.
module gf180mcu_osu_sc_rr_arb #(
    parameter int N = 2,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [N-1:0]  mask,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx
);

    logic [N-1:0] eligible;
    logic         found;
    int unsigned  pos;

    always_comb begin
        eligible = req & mask;
        grant    = '0;
        idx      = '0;
        found    = 1'b0;
        pos      = 0;
        for (int unsigned k = 0; k < N; k++) begin
            pos = (32'(ptr) + k) % N;
            if (!found && eligible[pos]) begin
                grant[pos] = 1'b1;
                idx        = IW'(pos);
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/gf180mcu_osu_sc_12t_latch_bank_ctrl.sv
// Write sequencer for a dlat-based storage bank: SETUP/OPEN/CLOSE around each word enable.
// Define LATCH_BANK_PARITY_EN to add the LAT_P even-parity output.
module gf180mcu_osu_sc_12t_latch_bank_ctrl
    import gf180mcu_osu_sc_latch_bank_pkg::*;
#(
    parameter int NREQ   = 2,
    parameter int NWORDS = 8,
    parameter int WIDTH  = 8,
    localparam int AW    = $clog2(NWORDS),
    localparam int IW    = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                  CLK,
    input  logic                  RN,
    input  logic [NREQ-1:0]       REQ,
    input  logic [NREQ*AW-1:0]    ADDR,
    input  logic [NREQ*WIDTH-1:0] WDATA,
    output logic [NREQ-1:0]       GNT,
    output logic                  ERR,
    output logic [WIDTH-1:0]      LAT_D,
    output logic [NWORDS-1:0]     LAT_EN,
    output logic                  BUSY
`ifdef LATCH_BANK_PARITY_EN
    ,
    output logic                  LAT_P
`endif
);

    state_t            state, state_nxt;
    logic [IW-1:0]     ptr, cap_idx, arb_idx;
    logic [NREQ-1:0]   arb_mask, arb_gnt, gnt_oh;
    logic [AW-1:0]     cap_addr, win_addr;
    logic [WIDTH-1:0]  win_data;
    logic [NWORDS-1:0] dec;
    logic              capture, addr_oor;

    gf180mcu_osu_sc_rr_arb #(.N(NREQ)) u_arb (
        .req   (REQ),
        .mask  (arb_mask),
        .ptr   (ptr),
        .grant (arb_gnt),
        .idx   (arb_idx)
    );

    assign win_addr = ADDR[32'(arb_idx)*AW +: AW];
    assign win_data = WDATA[32'(arb_idx)*WIDTH +: WIDTH];
    assign BUSY     = (state != IDLE);

    always_comb begin
        arb_mask = '1;
        gnt_oh   = '0;
        dec      = '0;
        gnt_oh[cap_idx] = 1'b1;
        // The word just written must not win the arbitration in its own CLOSE cycle.
        if (state == CLOSE) begin
            arb_mask[cap_idx] = 1'b0;
        end
        for (int unsigned w = 0; w < NWORDS; w++) begin
            dec[w] = (32'(cap_addr) == w);
        end
        addr_oor = (32'(cap_addr) >= NWORDS);
    end

    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        case (state)
            IDLE, CLOSE: begin
                if (|arb_gnt) begin
                    capture   = 1'b1;
                    state_nxt = SETUP;
                end else begin
                    state_nxt = IDLE;
                end
            end
            SETUP:   state_nxt = OPEN;
            OPEN:    state_nxt = CLOSE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RN) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RN) begin
            ptr      <= '0;
            cap_idx  <= '0;
            cap_addr <= '0;
            LAT_D    <= '0;
            LAT_EN   <= '0;
            GNT      <= '0;
            ERR      <= 1'b0;
`ifdef LATCH_BANK_PARITY_EN
            LAT_P    <= 1'b0;
`endif
        end else begin
            LAT_EN <= (state == SETUP) ? dec : '0;
            GNT    <= (state == OPEN) ? gnt_oh : '0;
            ERR    <= (state == OPEN) && addr_oor;
            if (capture) begin
                cap_idx  <= arb_idx;
                cap_addr <= win_addr;
                LAT_D    <= win_data;
                ptr      <= (32'(arb_idx) == NREQ - 1) ? '0 : arb_idx + 1'b1;
`ifdef LATCH_BANK_PARITY_EN
                LAT_P    <= ^win_data;
`endif
            end
        end
    end

endmodule

// File: tb/tb_gf180mcu_osu_sc_12t_latch_bank_ctrl.sv
// Directed bench for the latch-bank write controller (NWORDS=8 and NWORDS=6 instances).
module tb_gf180mcu_osu_sc_12t_latch_bank_ctrl;

    logic        CLK;
    logic        RN;
    logic [1:0]  REQ, REQ6;
    logic [5:0]  ADDR, ADDR6;
    logic [15:0] WDATA, WDATA6;
    logic [1:0]  GNT, GNT6;
    logic        ERR, ERR6;
    logic [7:0]  LAT_D, LAT_D6;
    logic [7:0]  LAT_EN;
    logic [5:0]  LAT_EN6;
    logic        BUSY, BUSY6;
`ifdef LATCH_BANK_PARITY_EN
    logic        LAT_P, LAT_P6;
`endif

    int checks = 0;
    int errors = 0;

    gf180mcu_osu_sc_12t_latch_bank_ctrl #(.NREQ(2), .NWORDS(8), .WIDTH(8)) dut (
        .CLK(CLK), .RN(RN), .REQ(REQ), .ADDR(ADDR), .WDATA(WDATA),
        .GNT(GNT), .ERR(ERR), .LAT_D(LAT_D), .LAT_EN(LAT_EN), .BUSY(BUSY)
`ifdef LATCH_BANK_PARITY_EN
        , .LAT_P(LAT_P)
`endif
    );

    gf180mcu_osu_sc_12t_latch_bank_ctrl #(.NREQ(2), .NWORDS(6), .WIDTH(8)) dut6 (
        .CLK(CLK), .RN(RN), .REQ(REQ6), .ADDR(ADDR6), .WDATA(WDATA6),
        .GNT(GNT6), .ERR(ERR6), .LAT_D(LAT_D6), .LAT_EN(LAT_EN6), .BUSY(BUSY6)
`ifdef LATCH_BANK_PARITY_EN
        , .LAT_P(LAT_P6)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic        rn;
        logic [1:0]  req;
        logic [5:0]  addr;
        logic [15:0] wdata;
        logic [1:0]  gnt;
        logic        err;
        logic [7:0]  d;
        logic [7:0]  en;
        logic        busy;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(logic rn, logic [1:0] req, logic [2:0] a1, logic [2:0] a0,
                                logic [7:0] w1, logic [7:0] w0, logic [1:0] gnt, logic err,
                                logic [7:0] d, logic [7:0] en, logic busy);
        vec_t v;
        v.rn = rn; v.req = req; v.addr = {a1, a0}; v.wdata = {w1, w0};
        v.gnt = gnt; v.err = err; v.d = d; v.en = en; v.busy = busy;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        RN = 1'b0; REQ = '0; ADDR = '0; WDATA = '0;
        REQ6 = '0; ADDR6 = '0; WDATA6 = '0;

        //          rn  req    a1  a0  w1     w0     gnt    err d      en     busy
        // reset
        vt.push_back(mk(0, 2'b00, 0, 0, 8'h00, 8'h00, 2'b00, 0, 8'h00, 8'h00, 0));
        vt.push_back(mk(0, 2'b00, 0, 0, 8'h00, 8'h00, 2'b00, 0, 8'h00, 8'h00, 0));
        // single write, requester 0, word 3
        vt.push_back(mk(1, 2'b01, 0, 3, 8'h00, 8'hA5, 2'b00, 0, 8'hA5, 8'h00, 1));
        vt.push_back(mk(1, 2'b01, 0, 3, 8'h00, 8'hA5, 2'b00, 0, 8'hA5, 8'h08, 1));
        vt.push_back(mk(1, 2'b01, 0, 3, 8'h00, 8'hA5, 2'b01, 0, 8'hA5, 8'h00, 1));
        vt.push_back(mk(1, 2'b00, 0, 3, 8'h00, 8'hA5, 2'b00, 0, 8'hA5, 8'h00, 0));
        vt.push_back(mk(1, 2'b00, 0, 0, 8'h00, 8'h00, 2'b00, 0, 8'hA5, 8'h00, 0));
        // requester 1 alone, word 5, then idle return holding LAT_D
        vt.push_back(mk(1, 2'b10, 5, 0, 8'h3C, 8'h00, 2'b00, 0, 8'h3C, 8'h00, 1));
        vt.push_back(mk(1, 2'b10, 5, 0, 8'h3C, 8'h00, 2'b00, 0, 8'h3C, 8'h20, 1));
        vt.push_back(mk(1, 2'b10, 5, 0, 8'h3C, 8'h00, 2'b10, 0, 8'h3C, 8'h00, 1));
        vt.push_back(mk(1, 2'b00, 5, 0, 8'h3C, 8'h00, 2'b00, 0, 8'h3C, 8'h00, 0));
        vt.push_back(mk(1, 2'b00, 0, 0, 8'h00, 8'h00, 2'b00, 0, 8'h3C, 8'h00, 0));
        // reset then contention: grants 0,1,0,1
        vt.push_back(mk(0, 2'b00, 0, 0, 8'h00, 8'h00, 2'b00, 0, 8'h00, 8'h00, 0));
        vt.push_back(mk(1, 2'b11, 2, 1, 8'h22, 8'h11, 2'b00, 0, 8'h11, 8'h00, 1));
        vt.push_back(mk(1, 2'b11, 2, 1, 8'h22, 8'h11, 2'b00, 0, 8'h11, 8'h02, 1));
        vt.push_back(mk(1, 2'b11, 2, 1, 8'h22, 8'h11, 2'b01, 0, 8'h11, 8'h00, 1));
        vt.push_back(mk(1, 2'b11, 2, 1, 8'h22, 8'h11, 2'b00, 0, 8'h22, 8'h00, 1));
        vt.push_back(mk(1, 2'b11, 2, 1, 8'h22, 8'h11, 2'b00, 0, 8'h22, 8'h04, 1));
        vt.push_back(mk(1, 2'b11, 2, 1, 8'h22, 8'h11, 2'b10, 0, 8'h22, 8'h00, 1));
        vt.push_back(mk(1, 2'b11, 2, 1, 8'h22, 8'h11, 2'b00, 0, 8'h11, 8'h00, 1));
        vt.push_back(mk(1, 2'b11, 2, 1, 8'h22, 8'h11, 2'b00, 0, 8'h11, 8'h02, 1));
        vt.push_back(mk(1, 2'b11, 2, 1, 8'h22, 8'h11, 2'b01, 0, 8'h11, 8'h00, 1));
        vt.push_back(mk(1, 2'b11, 2, 1, 8'h22, 8'h11, 2'b00, 0, 8'h22, 8'h00, 1));
        vt.push_back(mk(1, 2'b11, 2, 1, 8'h22, 8'h11, 2'b00, 0, 8'h22, 8'h04, 1));
        vt.push_back(mk(1, 2'b11, 2, 1, 8'h22, 8'h11, 2'b10, 0, 8'h22, 8'h00, 1));
        vt.push_back(mk(1, 2'b00, 2, 1, 8'h22, 8'h11, 2'b00, 0, 8'h22, 8'h00, 0));

        for (int i = 0; i < vt.size(); i++) begin
            RN = vt[i].rn; REQ = vt[i].req; ADDR = vt[i].addr; WDATA = vt[i].wdata;
            tick();
            chk($sformatf("v%0d_gnt", i),    32'(GNT),    32'(vt[i].gnt));
            chk($sformatf("v%0d_err", i),    32'(ERR),    32'(vt[i].err));
            chk($sformatf("v%0d_lat_d", i),  32'(LAT_D),  32'(vt[i].d));
            chk($sformatf("v%0d_lat_en", i), 32'(LAT_EN), 32'(vt[i].en));
            chk($sformatf("v%0d_busy", i),   32'(BUSY),   32'(vt[i].busy));
        end

        // out-of-range address on the 6-word instance: enables stay low, ERR with GNT
        RN = 1'b0; tick(); RN = 1'b1;
        REQ6 = 2'b01; ADDR6 = {3'd0, 3'd7}; WDATA6 = {8'h00, 8'h5A};
        tick();
        chk("oor_setup_d", 32'(LAT_D6), 32'h5A);
        chk("oor_setup_en", 32'(LAT_EN6), 32'h0);
        tick();
        chk("oor_open_en", 32'(LAT_EN6), 32'h0);
        chk("oor_open_busy", 32'(BUSY6), 32'h1);
        tick();
        chk("oor_close_en", 32'(LAT_EN6), 32'h0);
        chk("oor_close_gnt", 32'(GNT6), 32'h1);
        chk("oor_close_err", 32'(ERR6), 32'h1);
        REQ6 = 2'b00;
        tick();
        chk("oor_after_gnt", 32'(GNT6), 32'h0);
        chk("oor_after_err", 32'(ERR6), 32'h0);
        chk("oor_after_busy", 32'(BUSY6), 32'h0);
        // highest legal word of the 6-word instance
        REQ6 = 2'b10; ADDR6 = {3'd5, 3'd0}; WDATA6 = {8'hC3, 8'h00};
        tick();
        chk("top_setup_d", 32'(LAT_D6), 32'hC3);
        tick();
        chk("top_open_en", 32'(LAT_EN6), 32'h20);
        tick();
        chk("top_close_gnt", 32'(GNT6), 32'h2);
        chk("top_close_err", 32'(ERR6), 32'h0);
        REQ6 = 2'b00;
        tick();

        // reset while a word enable is open
        REQ = 2'b01; ADDR = {3'd0, 3'd4}; WDATA = {8'h00, 8'h77};
        tick();
        tick();
        chk("rst_open_en", 32'(LAT_EN), 32'h10);
        RN = 1'b0; REQ = 2'b00;
        tick();
        chk("rst_en", 32'(LAT_EN), 32'h0);
        chk("rst_gnt", 32'(GNT), 32'h0);
        chk("rst_busy", 32'(BUSY), 32'h0);
        tick();
        chk("rst_gnt2", 32'(GNT), 32'h0);
        RN = 1'b1; REQ = 2'b11; ADDR = {3'd6, 3'd0}; WDATA = {8'h02, 8'h01};
        tick();
        chk("rst_ptr_d", 32'(LAT_D), 32'h01);
        tick();
        chk("rst_ptr_en", 32'(LAT_EN), 32'h01);
        tick();
        chk("rst_ptr_gnt", 32'(GNT), 32'h1);
        REQ = 2'b10;
        tick();
        chk("rst_next_d", 32'(LAT_D), 32'h02);
        tick();
        chk("rst_next_en", 32'(LAT_EN), 32'h40);
        tick();
        chk("rst_next_gnt", 32'(GNT), 32'h2);
        REQ = 2'b00;
        tick();
        chk("rst_idle_busy", 32'(BUSY), 32'h0);

`ifdef LATCH_BANK_PARITY_EN
        REQ = 2'b01; ADDR = {3'd0, 3'd2}; WDATA = {8'h00, 8'h07};
        tick();
        chk("par_07_d", 32'(LAT_D), 32'h07);
        chk("par_07_p", 32'(LAT_P), 32'h1);
        tick();
        tick();
        REQ = 2'b00;
        tick();
        REQ = 2'b01; WDATA = {8'h00, 8'h03};
        tick();
        chk("par_03_d", 32'(LAT_D), 32'h03);
        chk("par_03_p", 32'(LAT_P), 32'h0);
        tick();
        tick();
        REQ = 2'b00;
        tick();
        chk("par_hold_p", 32'(LAT_P), 32'h0);
        chk("par6_p", 32'(LAT_P6), 32'h0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
